// File: rtl/instruction_loader_pkg.sv
// Shared loader definitions: frame sync byte, instruction width and loader state encodings.
// Sits alongside the MiniAlu ISA opcode defines.
package instruction_loader_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int         INSN_WIDTH       = 28;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } loader_state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs four payload bytes MSB-first into one instruction word and keeps the running
// XOR of every payload byte accepted since the last clear.
module loader_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [7:0]            byte_i,
  output logic [INSN_WIDTH-1:0] word_o,
  output logic                  word_last_o,
  output logic                  nibble_err_o,
  output logic [7:0]            chk_o
);

  logic [INSN_WIDTH-1:0] word_q;
  logic [1:0]            idx_q;
  logic [7:0]            chk_q;

  // The upper nibble of byte 0 falls off the top after the fourth shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      chk_q  <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      idx_q  <= '0;
      chk_q  <= '0;
    end else if (load_i) begin
      word_q <= {word_q[INSN_WIDTH-9:0], byte_i};
      idx_q  <= idx_q + 2'd1;
      chk_q  <= chk_q ^ byte_i;
    end
  end

  assign word_o       = word_q;
  assign word_last_o  = (idx_q == 2'd3);
  assign nibble_err_o = (idx_q == 2'd0) && (byte_i[7:4] != 4'd0);
  assign chk_o        = chk_q;

endmodule

// File: rtl/instruction_loader.sv
// Loads a framed byte stream into the MiniAlu instruction RAM and releases the core
// only once a complete image with a matching checksum has been written.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  input  logic                  iStart,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [INSN_WIDTH-1:0] oWriteData,
  output logic                  oCoreReset,
  output logic                  oDone,
  output logic                  oError
);

  loader_state_e         state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic                  ready_q, we_q, core_rst_q, done_q, err_q;

  logic                  xfer;
  logic                  asm_load, asm_clear, asm_last, asm_nib_err;
  logic [7:0]            asm_chk;
  logic [15:0]           cnt_full;
  logic [ADDR_WIDTH-1:0] word_inc;

  assign xfer = iByteValid & ready_q;

  loader_word_assembler u_asm (
    .clk          (Clock),
    .rst_n        (Reset_n),
    .clear_i      (asm_clear),
    .load_i       (asm_load),
    .byte_i       (iByte),
    .word_o       (oWriteData),
    .word_last_o  (asm_last),
    .nibble_err_o (asm_nib_err),
    .chk_o        (asm_chk)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    word_d    = word_q;
    asm_load  = 1'b0;
    asm_clear = 1'b0;
    cnt_full  = {count_q[15:8], iByte};
    word_inc  = word_q + ADDR_WIDTH'(1);
    case (state_q)
      ST_SYNC: if (xfer && (iByte == LOADER_SYNC_BYTE)) state_d = ST_LEN_HI;
      ST_LEN_HI: if (xfer) begin
        count_d[15:8] = iByte;
        state_d       = ST_LEN_LO;
      end
      ST_LEN_LO: if (xfer) begin
        count_d = cnt_full;
        if ((cnt_full == 16'd0) || (32'(cnt_full) > 32'(DEPTH))) begin
          state_d = ST_ERROR;
        end else begin
          state_d   = ST_DATA;
          word_d    = '0;
          asm_clear = 1'b1;
        end
      end
      ST_DATA: if (xfer) begin
        asm_load = 1'b1;
        if (asm_nib_err)   state_d = ST_ERROR;
        else if (asm_last) state_d = ST_WRITE;
      end
      // Single-cycle bubble: the word counter doubles as the RAM address during the strobe.
      ST_WRITE: begin
        word_d  = word_inc;
        state_d = (word_inc == ADDR_WIDTH'(count_q)) ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: if (xfer) state_d = (iByte == asm_chk) ? ST_DONE : ST_ERROR;
      ST_DONE, ST_ERROR: if (iStart) state_d = ST_SYNC;
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_SYNC;
      count_q    <= '0;
      word_q     <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      ready_q    <= (state_d == ST_SYNC) || (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                    (state_d == ST_DATA) || (state_d == ST_CHECK);
      we_q       <= (state_d == ST_WRITE);
      core_rst_q <= (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_ERROR);
    end
  end

  assign oByteReady    = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = word_q;
  assign oCoreReset    = core_rst_q;
  assign oDone         = done_q;
  assign oError        = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: frames are parsed by a byte-level reference model and the
// observed RAM writes and status flags are compared against its prediction.
module tb_instruction_loader;

  localparam int DEPTH = 256;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  iByte = 8'h00;
  logic        iByteValid = 1'b0;
  logic        iStart = 1'b0;
  logic        oByteReady, oWriteEnable, oCoreReset, oDone, oError;
  logic [15:0] oWriteAddress;
  logic [27:0] oWriteData;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          gap_en = 1'b0;
  bit          start_noise = 1'b0;
  logic [7:0]  fr[$];
  logic [43:0] wr_q[$];
  logic [43:0] exp_q[$];
  int          exp_st;  // 0 still loading, 1 done, 2 error

  instruction_loader #(.ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .iByte         (iByte),
    .iByteValid    (iByteValid),
    .oByteReady    (oByteReady),
    .iStart        (iStart),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oCoreReset    (oCoreReset),
    .oDone         (oDone),
    .oError        (oError)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (oWriteEnable) wr_q.push_back({oWriteAddress, oWriteData});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [43:0] got, input logic [43:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: parse the frame bytes directly into expected writes and final status.
  function automatic void predict();
    int         i;
    logic [15:0] cnt;
    logic [7:0]  x;
    exp_q.delete();
    exp_st = 0;
    i = 0;
    while (i < fr.size() && fr[i] != 8'hA5) i++;
    if (i + 2 >= fr.size()) return;
    cnt = {fr[i+1], fr[i+2]};
    i += 3;
    if (cnt == 16'd0 || int'(cnt) > DEPTH) begin
      exp_st = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < int'(cnt); k++) begin
      if (i >= fr.size()) return;
      if (fr[i][7:4] != 4'd0) begin
        exp_st = 2;
        return;
      end
      if (i + 3 >= fr.size()) return;
      exp_q.push_back({16'(k), fr[i][3:0], fr[i+1], fr[i+2], fr[i+3]});
      x = x ^ fr[i] ^ fr[i+1] ^ fr[i+2] ^ fr[i+3];
      i += 4;
    end
    if (i < fr.size()) exp_st = (fr[i] == x) ? 1 : 2;
  endfunction

  // mode: 0 good, 1 bad checksum, 2 bad nibble (frame ends there), 3 count 0, 4 count > DEPTH
  task automatic build(input int mode, input int nw, input int njunk);
    logic [7:0]  b, x;
    logic [15:0] c;
    int          bad;
    fr.delete();
    for (int j = 0; j < njunk; j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      fr.push_back(b);
    end
    fr.push_back(8'hA5);
    if (mode == 3) begin
      fr.push_back(8'h00);
      fr.push_back(8'h00);
      return;
    end
    if (mode == 4) begin
      c = 16'($urandom_range(DEPTH + 1, 65535));
      fr.push_back(c[15:8]);
      fr.push_back(c[7:0]);
      return;
    end
    c = 16'(nw);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
    bad = $urandom_range(0, nw - 1);
    x = 8'h00;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom);
        if (j == 0) b[7:4] = 4'd0;
        if (mode == 2 && w == bad && j == 0) begin
          b[7:4] = 4'($urandom_range(1, 15));
          fr.push_back(b);
          return;
        end
        fr.push_back(b);
        x = x ^ b;
      end
    end
    fr.push_back(mode == 1 ? ~x : x);
  endtask

  // Drives at negedge; ready is stable until the next posedge, so valid&ready here is a transfer.
  task automatic send_byte(input logic [7:0] b);
    bit sent = 1'b0;
    int n = 0;
    while (!sent && n < 64) begin
      @(negedge Clock);
      n++;
      iStart = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (gap_en && $urandom_range(0, 2) == 0) begin
        iByteValid = 1'b0;
        iByte      = 8'($urandom);
      end else begin
        iByteValid = 1'b1;
        iByte      = b;
        if (oByteReady) sent = 1'b1;
      end
    end
    if (!sent) check_eq("send_timeout", 44'd0, 44'd1);
  endtask

  task automatic run_frame(input string tag);
    predict();
    wr_q.delete();
    foreach (fr[j]) send_byte(fr[j]);
    @(negedge Clock);
    iByteValid = 1'b0;
    iStart     = 1'b0;
    repeat (3) @(negedge Clock);
    check_eq({tag, "_nwr"}, 44'(wr_q.size()), 44'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < wr_q.size(); j++)
      check_eq({tag, "_wr"}, wr_q[j], exp_q[j]);
    check_eq({tag, "_done"}, 44'(oDone), 44'(exp_st == 1));
    check_eq({tag, "_err"}, 44'(oError), 44'(exp_st == 2));
    check_eq({tag, "_corerst"}, 44'(oCoreReset), 44'(exp_st != 1));
    check_eq({tag, "_ready"}, 44'(oByteReady), 44'(exp_st == 0));
    if (exp_st != 0) begin
      iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      check_eq({tag, "_rearm_err"}, 44'(oError), 44'd0);
      check_eq({tag, "_rearm_done"}, 44'(oDone), 44'd0);
      check_eq({tag, "_rearm_corerst"}, 44'(oCoreReset), 44'd1);
      check_eq({tag, "_rearm_ready"}, 44'(oByteReady), 44'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 44'(oByteReady), 44'd1);
    check_eq({tag, "_we"}, 44'(oWriteEnable), 44'd0);
    check_eq({tag, "_addr"}, 44'(oWriteAddress), 44'd0);
    check_eq({tag, "_data"}, 44'(oWriteData), 44'd0);
    check_eq({tag, "_corerst"}, 44'(oCoreReset), 44'd1);
    check_eq({tag, "_done"}, 44'(oDone), 44'd0);
    check_eq({tag, "_err"}, 44'(oError), 44'd0);
  endtask

  initial begin
    logic [7:0] x;
    repeat (3) @(negedge Clock);
    check_reset_values("rst");
    Reset_n = 1'b1;
    @(negedge Clock);

    // Case 1: single word, no gaps
    fr = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h03, 8'h00};
    run_frame("c1");
    if (wr_q.size() > 0) check_eq("c1_word", wr_q[0], {16'h0000, 28'h1020003});

    // Case 1 again with random valid gaps
    gap_en = 1'b1;
    fr = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h03, 8'h00};
    run_frame("c1_gaps");
    gap_en = 1'b0;

    // Case 2: leading junk, two words
    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h02,
           8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h03, 8'h11, 8'h22, 8'h33};
    x = 8'h00;
    for (int j = 6; j < 14; j++) x = x ^ fr[j];
    fr.push_back(x);
    run_frame("c2");

    // Case 3: bad checksum
    build(1, 3, 0);
    run_frame("c3");

    // Case 4: count 0 and count 257
    fr = '{8'hA5, 8'h00, 8'h00};
    run_frame("c4_zero");
    fr = '{8'hA5, 8'h01, 8'h01};
    run_frame("c4_257");

    // Case 5: bad high nibble on first payload byte
    fr = '{8'hA5, 8'h00, 8'h01, 8'h1F};
    run_frame("c5");

    // Case 6: reset after two payload bytes
    wr_q.delete();
    fr = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02};
    foreach (fr[j]) send_byte(fr[j]);
    @(negedge Clock);
    iByteValid = 1'b0;
    Reset_n    = 1'b0;
    #1;
    check_reset_values("c6_rst");
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    check_eq("c6_nwr", 44'(wr_q.size()), 44'd0);
    build(0, 2, 0);
    run_frame("c6_after");

    // Boundary: count == DEPTH is accepted
    build(0, DEPTH, 0);
    run_frame("depth");

    // Randomized frames with gaps and stray iStart pulses
    gap_en      = 1'b1;
    start_noise = 1'b1;
    for (int t = 0; t < 24; t++) begin
      build($urandom_range(0, 4), $urandom_range(1, 6), $urandom_range(0, 3));
      run_frame("rand");
    end
    gap_en      = 1'b0;
    start_noise = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
